byte_serial_addsub_ctrl: RTL and testbench
==========================================

Name: byte_serial_addsub_ctrl

Overview:
Multi-cycle add/subtract sequencer that computes an N-byte sum or difference by reusing one 8-bit add/sub slice, one byte per cycle, LSB first.
- Inter-byte carry is held in a register, so the long carry chain is broken into per-cycle 8-bit segments.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a fully unrolled wide ripple-carry adder.

Parameters:
NBYTES, 4, number of 8-bit slices per operand; operand width W = 8*NBYTES; legal range 2..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand bundle valid.
in_ready  output  1  controller can accept operands (high only in IDLE).
mode  input  1  0 = A+B, 1 = A-B; sampled on accept.
a  input  W  operand A; sampled on accept.
b  input  W  operand B; sampled on accept.
out_valid  output  1  result valid (high only in DONE).
out_ready  input  1  consumer accepts result.
s  output  W  result, modulo 2^W.
cout  output  1  final carry out; for subtract, 1 = no borrow (a >= b unsigned).
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low. rst_n=0 forces the following immediately, independent of clk:
  - state = IDLE, byte index = 0, carry register = 0.
  - Operand registers and s = 0; cout = 0, ovf = 0, out_valid = 0, in_ready = 1.
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready: latch a, b and mode; carry reg <= mode; idx <= 0; clear s; go to RUN.
- RUN, each cycle:
  - Slice inputs: a_byte = A[8*idx+:8], bx = mode ? ~B[8*idx+:8] : B[8*idx+:8], cin = carry reg.
  - s[8*idx+:8] <= slice sum; carry reg <= slice cout; idx <= idx+1.
  - On the cycle idx == NBYTES-1:
    - cout <= slice cout.
    - ovf <= (a_msb == bx_msb) & (sum_msb != a_msb), using bit 7 of the top byte.
    - go to DONE.
  - in_ready = 0 throughout RUN.
- DONE:
  - out_valid = 1; s, cout and ovf are held stable.
  - On out_valid & out_ready: go to IDLE.
  - No same-cycle accept of new operands: in_ready = 0 in DONE, so the next accept is earliest the cycle after the return to IDLE.
- Latency: accept at edge k → out_valid high after edge k+NBYTES. Throughput is one operation per NBYTES+2 cycles with out_ready held high.
- Boundary conditions:
  - in_valid while not in IDLE: ignored, no side effect.
  - Changes on a, b or mode after accept: no effect on the operation in flight.
  - out_ready while not in DONE: ignored.
  - s bytes not yet computed read 0 during RUN; s is only meaningful when out_valid = 1.
  - Reset mid-RUN or mid-DONE: the partial result is discarded and all outputs take their reset values asynchronously.
  - idx counts 0..NBYTES-1 and never wraps inside an operation; it is cleared on accept.
- Arithmetic: s = (A + (mode ? ~B : B) + mode) mod 2^W, bit-identical to a W-bit ripple add/sub with B inverted and carry-in = mode.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2.
  - BYTE_W = 8.
  - MODE_ADD = 0, MODE_SUB = 1.
- Sub-module addsub_slice8: combinational 8-bit slice.
  - Ports: a[7:0], b[7:0], inv, cin, sum[7:0], cout, msb_bx.
  - Inverts b when inv = 1 and uses the external cin.
  - Carry-in is separate from inv because only byte 0 receives carry-in = mode; higher bytes receive the registered carry.

Test Plan:
- Add, NBYTES=4: a=0x00000005, b=0x00000003, mode=0 → s=0x00000008, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, mode=0 → s=0x00000000, cout=1, ovf=0.
- Signed overflow on add: a=0x7FFFFFFF, b=0x00000001, mode=0 → s=0x80000000, cout=0, ovf=1.
- Subtract:
  - a=3, b=5 → s=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1 → s=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → s, cout and ovf stable, in_ready=0, new operands not taken. Then out_ready=1 → IDLE next cycle, and the new operands are accepted the following cycle.
- Async reset: assert rst_n=0 mid-clock during RUN at idx=2 → s=0, out_valid=0 and in_ready=1 immediately without a clock edge. After release, a=1, b=1, mode=0 → s=2 with normal 4-cycle latency.

Source files
------------

// File: rtl/byte_serial_addsub_ctrl_pkg.sv
// rtl/byte_serial_addsub_ctrl_pkg.sv - shared encodings for the byte-serial add/sub controller
package byte_serial_addsub_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/byte_serial_addsub_ctrl_addsub_slice8.sv
// rtl/byte_serial_addsub_ctrl_addsub_slice8.sv - combinational 8-bit add/sub slice with external carry-in
module addsub_slice8
    import byte_serial_addsub_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              inv,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              msb_bx
);

    logic [BYTE_W-1:0] bx;
    logic [BYTE_W:0]   total;

    // cin is kept apart from inv: only byte 0 takes cin = mode, later bytes take the stored carry
    assign bx     = inv ? ~b : b;
    assign total  = {1'b0, a} + {1'b0, bx} + {{BYTE_W{1'b0}}, cin};
    assign sum    = total[BYTE_W-1:0];
    assign cout   = total[BYTE_W];
    assign msb_bx = bx[BYTE_W-1];

endmodule

// File: rtl/byte_serial_addsub_ctrl.sv
// rtl/byte_serial_addsub_ctrl.sv - N-byte add/sub sequencer reusing one 8-bit slice, LSB byte first
module byte_serial_addsub_ctrl
    import byte_serial_addsub_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W*NBYTES-1:0] s,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       s_q, s_d;
    logic               mode_q, mode_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [BYTE_W-1:0]  a_byte, b_byte, slice_sum;
    logic               slice_cout, slice_msb_bx;
    logic               last_byte;

    // Constant-index byte mux keeps the select free of variable part-selects
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    addsub_slice8 u_slice (
        .a      (a_byte),
        .b      (b_byte),
        .inv    (mode_q),
        .cin    (carry_q),
        .sum    (slice_sum),
        .cout   (slice_cout),
        .msb_bx (slice_msb_bx)
    );

    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        mode_d    = mode_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    carry_d = mode;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        s_d[i*BYTE_W +: BYTE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (last_byte) begin
                    // idx parks on the top byte rather than wrapping
                    cout_d  = slice_cout;
                    ovf_d   = (a_byte[BYTE_W-1] == slice_msb_bx) &&
                              (slice_sum[BYTE_W-1] != a_byte[BYTE_W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            mode_q  <= MODE_ADD;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_byte_serial_addsub_ctrl.sv
// tb/tb_byte_serial_addsub_ctrl.sv - directed self-checking bench for byte_serial_addsub_ctrl
module tb_byte_serial_addsub_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;

    byte_serial_addsub_ctrl #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic m, output int lat);
        @(negedge clk);
        a = av; b = bv; mode = m; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv; mode = ~m;
        wait_done(lat);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL reset_s got %h want 00000000", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_add();
        int lat;
        do_op(32'h00000005, 32'h00000003, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++; if (s !== 32'h00000008) begin errors++; $display("FAIL add_s got %h want 00000008", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got %0b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got %0b want 0", ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_done_in_ready got %0b want 0", in_ready); end
        pop();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL add_pop got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_ripple();
        int lat;
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        checks++; if (s !== 32'h00000000) begin errors++; $display("FAIL ripple_s got %h want 00000000", s); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got %0b want 1", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ripple_ovf got %0b want 0", ovf); end
        pop();
    endtask

    task automatic test_add_overflow();
        int lat;
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        checks++; if (s !== 32'h80000000) begin errors++; $display("FAIL addovf_s got %h want 80000000", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL addovf_cout got %0b want 0", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL addovf_ovf got %0b want 1", ovf); end
        pop();
    endtask

    task automatic test_subtract();
        int lat;
        do_op(32'h00000003, 32'h00000005, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got %0d want 4", lat); end
        checks++; if (s !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_s got %h want fffffffe", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_cout got %0b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf got %0b want 0", ovf); end
        pop();
        do_op(32'h80000000, 32'h00000001, 1'b1, lat);
        checks++; if (s !== 32'h7FFFFFFF) begin errors++; $display("FAIL subovf_s got %h want 7fffffff", s); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL subovf_cout got %0b want 1", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL subovf_ovf got %0b want 1", ovf); end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h0000000A, 32'h00000004, 1'b1, lat);
        in_valid = 1'b1; a = 32'h11111111; b = 32'h22222222; mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 32'h00000006 || cout !== 1'b1 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got ov=%0b ir=%0b s=%h c=%0b o=%0b want 1 0 00000006 1 0", i, out_valid, in_ready, s, cout, ovf);
            end
        end
        pop();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_next_latency got %0d want 4", lat); end
        checks++; if (s !== 32'h33333333 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL bp_next_result got s=%h c=%0b o=%0b want 33333333 0 0", s, cout, ovf); end
        pop();
    endtask

    task automatic test_async_reset();
        int lat;
        @(negedge clk);
        a = 32'h01020304; b = 32'h01010101; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s !== 32'h00000405) begin errors++; $display("FAIL partial_s got %h want 00000405", s); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got s=%h ov=%0b ir=%0b want 00000000 0 1", s, out_valid, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h00000001, 32'h00000001, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_after_latency got %0d want 4", lat); end
        checks++; if (s !== 32'h00000002) begin errors++; $display("FAIL rst_after_s got %h want 00000002", s); end
        pop();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_ripple();
        test_add_overflow();
        test_subtract();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
